// File: rtl/vector_load_unit.sv
// Strided vector load: fetches LANES words one request at a time and writes the assembled vector to the VRF.
// Define VLOAD_BCAST_EN to add the bcast input (single fetch replicated into every lane).
module vector_load_unit #(
  parameter int WORD_W = 32,
  parameter int LANES  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       vaddr_base,
  input  logic [31:0]       vstride,
  input  logic [4:0]        vdst,
`ifdef VLOAD_BCAST_EN
  input  logic              bcast,
`endif
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              vwe3,
  output logic [4:0]        vwa3,
  output logic [255:0]      vwd3,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int VEC_W  = WORD_W * LANES;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WRITE} state_t;

  state_t            state_reg;
  logic [LANE_W-1:0] lane_reg;
  logic [31:0]       addr_reg;
  logic [31:0]       stride_reg;
  logic [4:0]        vdst_reg;
  logic              mem_req_reg;
  logic              vwe3_reg;
  logic              done_reg;
  logic              err_reg;
  logic [4:0]        vwa3_reg;
  logic [255:0]      vwd3_reg;
  logic [VEC_W-1:0]  vec_reg;
  logic [VEC_W-1:0]  vec_next;
  logic              bcast_reg;
  logic              capture;
  logic              last_word;
  logic              dst_ok;

  // Only registers v16..v23 are legal load targets.
  assign dst_ok    = (vdst[4:3] == 2'b10);
  assign capture   = (state_reg == WAIT) && mem_rvalid;
  assign last_word = (lane_reg == LAST_LANE) || bcast_reg;

`ifdef VLOAD_BCAST_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcast_reg <= 1'b0;
    end else if (state_reg == IDLE && start && dst_ok) begin
      bcast_reg <= bcast;
    end
  end
`else
  assign bcast_reg = 1'b0;
`endif

  // Per-lane capture registers; vec_next already includes the word arriving this cycle.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [WORD_W-1:0] word_reg;
      logic              hit;

      assign hit = capture && (bcast_reg || (lane_reg == LANE_W'(gi)));
      assign vec_next[gi*WORD_W +: WORD_W] = hit ? mem_rdata : word_reg;
      assign vec_reg[gi*WORD_W +: WORD_W]  = word_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          word_reg <= '0;
        end else begin
          word_reg <= vec_next[gi*WORD_W +: WORD_W];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      lane_reg    <= '0;
      addr_reg    <= '0;
      stride_reg  <= '0;
      vdst_reg    <= '0;
      mem_req_reg <= 1'b0;
      vwe3_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      vwa3_reg    <= '0;
      vwd3_reg    <= '0;
    end else begin
      vwe3_reg <= 1'b0;
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (dst_ok) begin
              addr_reg    <= vaddr_base;
              stride_reg  <= vstride;
              vdst_reg    <= vdst;
              lane_reg    <= '0;
              mem_req_reg <= 1'b1;
              state_reg   <= REQ;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req_reg <= 1'b0;
            state_reg   <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            if (last_word) begin
              vwe3_reg  <= 1'b1;
              done_reg  <= 1'b1;
              vwa3_reg  <= vdst_reg;
              vwd3_reg  <= vec_next;
              state_reg <= WRITE;
            end else begin
              // Running sum gives base+lane*stride modulo 2^32 without a multiplier.
              lane_reg    <= lane_reg + LANE_W'(1);
              addr_reg    <= addr_reg + stride_reg;
              mem_req_reg <= 1'b1;
              state_reg   <= REQ;
            end
          end
        end
        WRITE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign mem_req  = mem_req_reg;
  assign mem_addr = addr_reg;
  assign vwe3     = vwe3_reg;
  assign vwa3     = vwa3_reg;
  assign vwd3     = vwd3_reg;
  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_vector_load_unit.sv
// Bench for vector_load_unit: randomized memory responder checked against a lane/address model.
module tb_vector_load_unit;
  localparam int LANES = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [31:0]  vaddr_base = '0;
  logic [31:0]  vstride = '0;
  logic [4:0]   vdst = '0;
`ifdef VLOAD_BCAST_EN
  logic         bcast = 1'b0;
`endif
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_gnt = 1'b0;
  logic         mem_rvalid = 1'b0;
  logic [31:0]  mem_rdata = '0;
  logic         vwe3;
  logic [4:0]   vwa3;
  logic [255:0] vwd3;
  logic         busy;
  logic         done;
  logic         err;

  int total = 0;
  int bad = 0;

  vector_load_unit #(.WORD_W(32), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .start(start), .vaddr_base(vaddr_base), .vstride(vstride), .vdst(vdst),
`ifdef VLOAD_BCAST_EN
    .bcast(bcast),
`endif
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .vwe3(vwe3), .vwa3(vwa3), .vwd3(vwd3), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Memory data returned for a word is (addr+1)^salt, so salt=0 gives addr+1.
  task automatic run_load(input logic [31:0] base, input logic [31:0] stride, input logic [4:0] dst,
                          input int gnt_dly, input int rv_dly, input bit bc, input int abort_lane,
                          input bit noise, input logic [31:0] salt);
    logic [31:0]  exp_addr [LANES];
    logic [31:0]  data [LANES];
    logic [255:0] exp_vec;
    logic [31:0]  held;
    int n_words, exp_cyc, req_idx, wait_cnt, rv_cnt, cyc, bad0;
    bit finished, abort_now;
    bad0 = bad;
    n_words = bc ? 1 : LANES;
    for (int i = 0; i < LANES; i++) begin
      exp_addr[i] = base + stride * 32'(i);
      data[i] = (exp_addr[i] + 32'd1) ^ salt;
    end
    for (int i = 0; i < LANES; i++) exp_vec[i*32 +: 32] = bc ? data[0] : data[i];
    exp_cyc = 1 + n_words * (gnt_dly + 1 + rv_dly + 1);
    @(negedge clk);
    start = 1'b1; vaddr_base = base; vstride = stride; vdst = dst;
`ifdef VLOAD_BCAST_EN
    bcast = bc;
`endif
    req_idx = 0; wait_cnt = 0; rv_cnt = -1; cyc = 0; finished = 0; abort_now = 0; held = '0;
    while (!finished && cyc < exp_cyc + 4) begin
      @(negedge clk);
      cyc++;
      if (noise) begin
        start = 1'($urandom_range(0, 1)); vdst = 5'($urandom); vaddr_base = $urandom;
      end else begin
        start = 1'b0;
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (abort_now) begin
        start = 1'b0;
        #2 rst = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || mem_req !== 1'b0 || vwe3 !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
          bad++; $display("FAIL abort_ctrl got busy=%b req=%b we=%b done=%b err=%b want all 0", busy, mem_req, vwe3, done, err); end
        total++; if (vwd3 !== '0 || vwa3 !== 5'd0 || mem_addr !== 32'd0) begin
          bad++; $display("FAIL abort_data got vwd3=%h vwa3=%h addr=%h want 0", vwd3, vwa3, mem_addr); end
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          if (k == 2) rst = 1'b1;
          mem_rvalid = 1'b1; mem_rdata = $urandom;
          total++; if (vwe3 !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0) begin
            bad++; $display("FAIL abort_late got we=%b busy=%b req=%b want 0", vwe3, busy, mem_req); end
        end
        @(negedge clk); mem_rvalid = 1'b0;
        total++; if (vwe3 !== 1'b0 || vwd3 !== '0) begin
          bad++; $display("FAIL abort_nowrite got we=%b vwd3=%h want 0", vwe3, vwd3); end
        $display("abort dst=%0d base=%h after lane %0d %s", dst, base, abort_lane, (bad == bad0) ? "ok" : "bad");
        return;
      end
      if (vwe3 === 1'b1) begin
        start = 1'b0; finished = 1;
        total++; if (cyc != exp_cyc) begin bad++; $display("FAIL latency got=%0d want=%0d", cyc, exp_cyc); end
        total++; if (vwa3 !== dst) begin bad++; $display("FAIL vwa3 got=%0d want=%0d", vwa3, dst); end
        total++; if (vwd3 !== exp_vec) begin bad++; $display("FAIL vwd3 got=%h want=%h", vwd3, exp_vec); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL done got=%b want=1", done); end
        total++; if (req_idx != n_words) begin bad++; $display("FAIL nreq got=%0d want=%0d", req_idx, n_words); end
      end else begin
        total++; if (busy !== 1'b1 || err !== 1'b0 || done !== 1'b0) begin
          bad++; $display("FAIL busy cyc=%0d got busy=%b err=%b done=%b want 1/0/0", cyc, busy, err, done); end
        if (rv_cnt >= 0) begin
          total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL outstanding cyc=%0d got req=%b want 0", cyc, mem_req); end
          if (rv_cnt == 0) begin
            mem_rvalid = 1'b1; mem_rdata = data[req_idx-1]; rv_cnt = -1;
            if (req_idx - 1 == abort_lane) abort_now = 1;
          end else begin
            rv_cnt--;
          end
        end else begin
          total++;
          if (mem_req !== 1'b1) begin
            bad++; $display("FAIL mem_req cyc=%0d got=%b want=1", cyc, mem_req);
          end else if (req_idx >= n_words) begin
            bad++; $display("FAIL extra_req cyc=%0d got=%0d want<%0d", cyc, req_idx, n_words);
          end else if (wait_cnt == 0 && mem_addr !== exp_addr[req_idx]) begin
            bad++; $display("FAIL mem_addr lane=%0d got=%h want=%h", req_idx, mem_addr, exp_addr[req_idx]);
          end else if (wait_cnt > 0 && mem_addr !== held) begin
            bad++; $display("FAIL addr_stable lane=%0d got=%h want=%h", req_idx, mem_addr, held);
          end
          if (mem_req === 1'b1 && req_idx < n_words) begin
            if (wait_cnt == 0) held = exp_addr[req_idx];
            if (wait_cnt == gnt_dly) begin
              mem_gnt = 1'b1;
              if (noise) mem_rvalid = 1'b1;
              req_idx++; wait_cnt = 0; rv_cnt = rv_dly;
            end else begin
              wait_cnt++;
            end
          end
        end
      end
    end
    total++; if (!finished) begin bad++; $display("FAIL timeout got=%0d cycles want write by %0d", cyc, exp_cyc); end
    @(negedge clk);
    start = 1'b0; mem_rvalid = 1'b1; mem_rdata = $urandom;
    total++; if (vwe3 !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL after_write got we=%b done=%b busy=%b want 0", vwe3, done, busy); end
    @(negedge clk);
    mem_rvalid = 1'b0;
    total++; if (vwd3 !== exp_vec || vwa3 !== dst) begin
      bad++; $display("FAIL hold got vwd3=%h vwa3=%0d want %h/%0d", vwd3, vwa3, exp_vec, dst); end
    $display("load dst=%0d base=%h stride=%h gnt=%0d rv=%0d bc=%0d %s", dst, base, stride, gnt_dly, rv_dly, bc,
             (bad == bad0) ? "ok" : "bad");
  endtask

  task automatic test_reset();
    #1;
    total++; if (busy !== 1'b0 || mem_req !== 1'b0 || vwe3 !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl got busy=%b req=%b we=%b done=%b err=%b want 0", busy, mem_req, vwe3, done, err); end
    total++; if (vwd3 !== '0 || vwa3 !== 5'd0 || mem_addr !== 32'd0) begin
      bad++; $display("FAIL reset_data got vwd3=%h vwa3=%h addr=%h want 0", vwd3, vwa3, mem_addr); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    $display("reset check done");
  endtask

  task automatic test_err();
    logic [4:0] bad_dst [5];
    bad_dst[0] = 5'd5; bad_dst[1] = 5'd0; bad_dst[2] = 5'd15; bad_dst[3] = 5'd24; bad_dst[4] = 5'd31;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); start = 1'b1; vdst = bad_dst[i]; vaddr_base = $urandom;
      @(negedge clk); start = 1'b0;
      total++; if (err !== 1'b1 || mem_req !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL err_pulse dst=%0d got err=%b req=%b busy=%b want 1/0/0", bad_dst[i], err, mem_req, busy); end
      @(negedge clk);
      total++; if (err !== 1'b0 || mem_req !== 1'b0 || vwe3 !== 1'b0) begin
        bad++; $display("FAIL err_after dst=%0d got err=%b req=%b we=%b want 0", bad_dst[i], err, mem_req, vwe3); end
      $display("err dst=%0d", bad_dst[i]);
    end
  endtask

  task automatic test_reset_start();
    @(negedge clk); rst = 1'b0; start = 1'b1; vdst = 5'd20;
    @(negedge clk);
    total++; if (busy !== 1'b0 || mem_req !== 1'b0) begin
      bad++; $display("FAIL rst_vs_start got busy=%b req=%b want 0", busy, mem_req); end
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || mem_req !== 1'b0) begin
      bad++; $display("FAIL rst_release got busy=%b req=%b want 0", busy, mem_req); end
    $display("reset vs start checked");
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      run_load($urandom, $urandom, 5'(16 + $urandom_range(0, 7)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), 1'b0, -1, 1'b1, $urandom);
    end
  endtask

  initial begin
    test_reset();
    run_load(32'h100, 32'd4, 5'd17, 0, 0, 1'b0, -1, 1'b0, 32'd0);
    run_load(32'h100, 32'd4, 5'd17, 3, 0, 1'b0, -1, 1'b0, 32'd0);
    test_err();
    run_load(32'hFFFF_FFF8, 32'd4, 5'd16, 0, 1, 1'b0, -1, 1'b0, 32'd0);
    run_load(32'h4000, 32'hFFFF_FFF0, 5'd23, 1, 2, 1'b0, -1, 1'b1, 32'h1234_5678);
    test_random();
    run_load(32'h800, 32'd8, 5'd18, 1, 1, 1'b0, 4, 1'b0, 32'h5A5A_0000);
    run_load(32'h100, 32'd4, 5'd19, 0, 0, 1'b0, -1, 1'b0, 32'd0);
    test_reset_start();
`ifdef VLOAD_BCAST_EN
    run_load(32'h2000, 32'h40, 5'd21, 0, 0, 1'b1, -1, 1'b0, (32'h2000 + 32'd1) ^ 32'hDEAD_BEEF);
    run_load(32'h3000, 32'h40, 5'd22, 2, 1, 1'b0, -1, 1'b0, 32'h0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vector_load_unit.md
VECTOR_LOAD_UNIT -- requirements
Module: vector_load_unit

Interface
REQ-001 SHALL have parameter WORD_W, default 32: memory word width in bits.
REQ-002 SHALL have parameter LANES, default 8: words per vector; WORD_W*LANES SHALL equal 256.
REQ-003 SHALL have port clk, input, 1: single clock; all flops rise on posedge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: one-cycle load request; sampled only in IDLE.
REQ-006 SHALL have port vaddr_base, input, 32: byte address of lane 0.
REQ-007 SHALL have port vstride, input, 32: byte distance between consecutive lanes.
REQ-008 SHALL have port vdst, input, 5: destination vector register index.
REQ-009 SHALL have port mem_req, output, 1: memory read request.
REQ-010 SHALL have port mem_addr, output, 32: request address, valid while mem_req=1.
REQ-011 SHALL have port mem_gnt, input, 1: request accepted in the cycle it is high with mem_req.
REQ-012 SHALL have port mem_rvalid, input, 1: read data valid.
REQ-013 SHALL have port mem_rdata, input, WORD_W: read data.
REQ-014 SHALL have port vwe3, output, 1: vector register file write enable.
REQ-015 SHALL have port vwa3, output, 5: vector register file write address.
REQ-016 SHALL have port vwd3, output, 256: vector register file write data.
REQ-017 SHALL have ports busy (1, high outside IDLE), done (1, one-cycle pulse) and err (1, one-cycle pulse), all outputs.

Function
REQ-018 SHALL implement FSM states IDLE, REQ, WAIT, WRITE.
REQ-019 In IDLE, when start=1 and vdst is in 16..23, SHALL latch base, stride and vdst, clear the lane counter, and go to REQ.
REQ-020 In IDLE, when start=1 and vdst is outside 16..23, SHALL pulse err for one cycle, stay in IDLE, and issue no memory traffic and no write.
REQ-021 In REQ, SHALL drive mem_req=1 with mem_addr=base+lane*stride, computed modulo 2^32 (wrap-around, no error).
REQ-022 SHALL hold mem_req and mem_addr stable until mem_gnt=1, then go to WAIT on the next cycle.
REQ-023 SHALL keep at most one request outstanding.
REQ-024 In WAIT, on mem_rvalid=1, SHALL store mem_rdata into lane bits [lane*WORD_W +: WORD_W], with lane 0 at bits [31:0].
REQ-025 After the REQ-024 capture, SHALL go to WRITE if lane==LANES-1; otherwise it SHALL increment lane and return to REQ.
REQ-026 SHALL ignore mem_rvalid in every state other than WAIT; rvalid arriving in the same cycle as gnt SHALL be ignored.
REQ-027 In WRITE, SHALL assert vwe3=1 for exactly one cycle with vwa3=latched vdst and vwd3=assembled vector, pulse done in the same cycle, and go to IDLE.
REQ-028 Outside WRITE, vwe3 SHALL be 0; vwd3 and vwa3 SHALL hold their last values.
REQ-029 SHALL ignore start while busy=1.
REQ-030 Minimum latency from start to vwe3 SHALL be 1+2*LANES cycles (gnt in first REQ cycle, rvalid in first WAIT cycle).

Reset
REQ-031 rst=0 SHALL immediately, without waiting for clk, force IDLE, lane=0, and set mem_req, vwe3, busy, done and err to 0 and vwd3, vwa3 and mem_addr to 0.
REQ-032 Reset mid-load SHALL abandon the load with no register write; any late mem_rvalid SHALL be ignored.
REQ-033 When rst=0 and start=1 occur in the same cycle, reset SHALL win.

Configuration
REQ-034 With VLOAD_BCAST_EN defined, SHALL add a 1-bit input bcast, sampled with start; when bcast=1, SHALL fetch only the word at base and replicate it into all LANES lanes, so the latency is 3 cycles.
REQ-035 Without VLOAD_BCAST_EN, SHALL omit the bcast port and always perform a strided load per REQ-021..REQ-025.

Verification
REQ-036 Bench SHALL cover: base=0x100, stride=4, vdst=17, mem returns addr+1 with zero wait -> 8 requests at 0x100..0x11C, vwe3 at cycle 17, vwa3=17, lane i = 0x101+4i.
REQ-037 Bench SHALL cover: same load with mem_gnt delayed 3 cycles per request -> mem_addr stable throughout, one outstanding request, correct vector.
REQ-038 Bench SHALL cover: vdst=5 -> err pulse, mem_req stays 0, vwe3 stays 0.
REQ-039 Bench SHALL cover: base=0xFFFFFFF8, stride=4 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, ..., 0x14.
REQ-040 Bench SHALL cover: rst=0 asserted after lane 4 captured -> outputs 0 asynchronously, no vwe3; a new load afterwards completes normally.
REQ-041 Bench SHALL cover: with VLOAD_BCAST_EN, bcast=1, word 0xDEADBEEF -> one request, vwd3 = 8 copies of 0xDEADBEEF.
